// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the multi-pass shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bits consumed by one pass: whatever remains, capped at the per-pass limit.
  function automatic int unsigned calc_step(int unsigned rem, int unsigned max_step);
    return (rem < max_step) ? rem : max_step;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Cheap per-pass shifter: logical shift by 0..MAX_STEP with zero fill.
module shift_step #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_STEP   = 3,
  parameter int STEP_W     = $clog2(MAX_STEP + 1)
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [STEP_W-1:0]     step,
  input  logic                  left,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    if (left) result = data << step;
    else      result = data >> step;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle logical shifter: iterates shift_step passes until the requested
// amount is consumed, then holds the result until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a command, in_ready high
// SHIFT | one pass per cycle until the remaining amount reaches zero
// DONE  | result presented on out_data with out_valid high
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int AMT_W      = 4,
  parameter int MAX_STEP   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0]      in_amt,
  input  logic                  in_left,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  localparam int REM_W  = $clog2(DATA_WIDTH + 1);
  localparam int STEP_W = $clog2(MAX_STEP + 1);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [REM_W-1:0]        rem_q, rem_d;
  logic                    dir_q, dir_d;

  logic [REM_W-1:0]        amt_sat;
  logic [REM_W-1:0]        rem_after;
  logic [STEP_W-1:0]       step;
  logic [DATA_WIDTH-1:0]   shifted;

  // Anything at or beyond the word width clears the word, so clip it there.
  always_comb begin
    if (int'(in_amt) >= DATA_WIDTH) amt_sat = REM_W'(DATA_WIDTH);
    else                            amt_sat = REM_W'(in_amt);
  end

  assign step      = STEP_W'(calc_step(32'(rem_q), MAX_STEP));
  assign rem_after = rem_q - REM_W'(step);

  shift_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_STEP   (MAX_STEP),
    .STEP_W     (STEP_W)
  ) u_shift_step (
    .data   (data_q),
    .step   (step),
    .left   (dir_q),
    .result (shifted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    dir_d   = dir_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          dir_d   = in_left;
          rem_d   = amt_sat;
          state_d = (amt_sat != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        data_d = shifted;
        rem_d  = rem_after;
        if (rem_after == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from registered state so reset reaches them at once.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: expected results are queued at accept
// and compared (data and latency) when the result is presented.
module tb_shift_sequencer;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_amt;
  logic          in_left;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;

  shift_sequencer #(.DATA_WIDTH(DW), .AMT_W(AW), .MAX_STEP(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_left   (in_left),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat_cnt  = 0;
  bit   timing   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: saturate the amount, shift in one go, passes = ceil(amt/3).
  function automatic exp_t model(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic l);
    int unsigned s;
    exp_t e;
    s = (int'(a) >= DW) ? DW : int'(a);
    e.data = l ? (d << s) : (d >> s);
    e.lat  = 1 + (s + 2) / 3;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      timing = 1'b0;
    end else begin
      if (timing) begin
        lat_cnt++;
        if (out_valid) begin
          timing = 1'b0;
          if (sb_q.size() > 0) chk("latency", lat_cnt, sb_q[0].lat);
        end
      end
      if (out_valid) begin
        chk("in_ready_in_done", in_ready, 1'b0);
        chk("busy_in_done", busy, 1'b1);
        if (sb_q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          chk("out_data", out_data, sb_q[0].data);
          if (out_ready) void'(sb_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        chk("accept_not_busy", busy, 1'b0);
        sb_q.push_back(model(in_data, in_amt, in_left));
        timing  = 1'b1;
        lat_cnt = 0;
      end
    end
  end

  // Called at a drive point (just after a rising edge); returns just after the accept edge.
  task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic l, input bit keep);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_left  = l;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_left   = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    #20;
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    send(8'hB5, 4'd5, 1'b1, 1'b0);  drain();
    send(8'hB5, 4'd7, 1'b0, 1'b0);  drain();
    send(8'h3C, 4'd0, 1'b1, 1'b0);  drain();
    send(8'hFF, 4'd12, 1'b1, 1'b0); drain();
    send(8'hC3, 4'd15, 1'b0, 1'b0); drain();
    send(8'h5A, 4'd8, 1'b0, 1'b0);  drain();

    // Backpressure with an ignored command pulse mid-hold.
    out_ready = 1'b0;
    send(8'h81, 4'd1, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_done", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i == 2);
      in_data  = 8'hFF;
      in_amt   = 4'd3;
      chk("bp_held_valid", out_valid, 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    chk("bp_release_queue", sb_q.size(), 0);

    // Asynchronous reset in the middle of a SHIFT.
    send(8'hA5, 4'd9, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_data", out_data, 8'h00);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    send(8'h01, 4'd2, 1'b1, 1'b0);  drain();

    // Back-to-back with in_valid held high across both commands.
    send(8'h96, 4'd4, 1'b0, 1'b1);
    send(8'h0F, 4'd3, 1'b1, 1'b1);
    in_valid = 1'b0;
    drain();

    for (int i = 0; i < 8; i++) begin
      send(8'($urandom_range(255)), 4'($urandom_range(15)), 1'($urandom_range(1)), 1'b0);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that sequences a small step shifter (0..MAX_STEP bits per pass) to perform logical left/right shifts of arbitrary amount on a DATA_WIDTH word.
- Accepts one command via valid/ready, iterates passes until the requested amount is consumed, then presents the result via valid/ready.
- Sits between a command source (e.g. ALU/issue logic) and the consumer.
- Trades latency for a cheap per-pass shifter instead of a full log-depth barrel.

Parameters:
- DATA_WIDTH, 8: data word width.
- AMT_W, 4: shift-amount field width; amounts 0..2^AMT_W-1.
- MAX_STEP, 3: maximum bits shifted per pass; must be >=1 and <DATA_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid & in_ready.
- in_data  in  DATA_WIDTH  operand.
- in_amt  in  AMT_W  shift amount.
- in_left  in  1  1 = left shift, 0 = logical right shift.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_data  out  DATA_WIDTH  shifted result.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0. Internal data/remaining/dir registers are cleared to 0.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE transition, on accept (in_valid & in_ready):
  - load data_r=in_data, dir_r=in_left, rem_r=min(in_amt, DATA_WIDTH).
  - Saturate rem_r at DATA_WIDTH; rem_r needs enough bits to hold DATA_WIDTH.
  - Next state SHIFT if the loaded rem_r != 0, else DONE.
- SHIFT, each cycle:
  - step = min(rem_r, MAX_STEP).
  - data_r <= step_shift(data_r, step, dir_r); zero-fill on the vacated side.
  - rem_r <= rem_r - step.
  - Go to DONE when rem_r - step == 0, else stay in SHIFT.
- DONE:
  - out_data = data_r, held stable while out_valid & !out_ready.
  - On out_ready go to IDLE.
  - No accept in the same cycle; in_ready is only high in IDLE. Throughput is one command per (passes + 2) cycles.
- Latency, for a command accepted at the edge of cycle T with passes p = ceil(min(amt, DATA_WIDTH)/MAX_STEP):
  - out_valid is first high in cycle T+1+p.
  - amt=0 gives out_valid in T+1 with out_data=in_data.
- Amount >= DATA_WIDTH: result is 0, with latency as for amt=DATA_WIDTH.
- in_valid while not in IDLE: ignored; in_data/in_amt/in_left may change freely.
- out_data outside DONE: holds data_r (intermediate values allowed). Consumers must qualify with out_valid.
- Reset asserted mid-SHIFT or mid-DONE: immediately returns to IDLE and all outputs take their reset values. The in-flight command is dropped.
- busy = (state != IDLE).

Decomposition:
- Package shift_seq_pkg:
  - state enum {IDLE, SHIFT, DONE} as 2-bit logic.
  - Function computing step = min(rem, MAX_STEP).
- Sub-module shift_step:
  - Purely combinational.
  - Ports: data, step[clog2(MAX_STEP+1)-1:0], left, result.
  - Zero-fill logical shift by 0..MAX_STEP.
  - Instantiated once inside shift_sequencer.

Test Plan:
- Left shift: accept 0xB5, amt=5, left=1 at T -> passes 3,2; out_valid at T+3 with out_data=0xA0.
- Right shift: accept 0xB5, amt=7, left=0 -> passes 3,3,1; out_valid at T+4 with out_data=0x01.
- Zero/saturated amounts:
  - amt=0, data 0x3C -> out_valid at T+1, out_data=0x3C.
  - amt=12, data 0xFF -> clipped to 8, passes 3,3,2; out_valid at T+4, out_data=0x00.
- Backpressure: complete 0x81 amt=1 left=1 -> 0x02, hold out_ready=0 for 5 cycles.
  - out_valid stays 1 and out_data stays 0x02; in_ready=0; a new in_valid pulse is ignored.
  - Raising out_ready returns to IDLE (in_ready=1) the next cycle.
- Reset mid-operation: assert rst asynchronously during SHIFT of amt=9.
  - Outputs go to reset values immediately (out_valid=0, out_data=0, in_ready=1, busy=0).
  - A subsequent command (0x01, amt=2, left=1) yields 0x04 at T+2.
- Back-to-back: two commands issued with in_valid held high -> second is accepted only in the cycle after the first's out_valid&out_ready handshake; both results are correct and in order.
